// File: rtl/uop_share_sched.sv
// Round-robin sharing of one pipelined microop ALU slot among NREQ requesters, with credit-protected result FIFO.
// Optional statistics counters are enabled by defining UOP_SCHED_STATS_EN.

package uop_pkg;
   typedef enum logic [3:0] {
      OP_NOP = 4'd0,
      OP_ADD,
      OP_SUB,
      OP_AND,
      OP_OR,
      OP_XOR,
      OP_SLL,
      OP_SRL,
      OP_SRA
   } op_t;
endpackage

module uop_share_sched #(
   parameter int NREQ   = 4,
   parameter int W      = 64,
   parameter int LAT    = 3,
   parameter int RDEPTH = 4,
   parameter int TAGW   = 4
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NREQ-1:0]                     req_valid_i,
   output logic [NREQ-1:0]                     req_ready_o,
   input  uop_pkg::op_t [NREQ-1:0]             req_op_i,
   input  logic [NREQ-1:0][W-1:0]              req_a_i,
   input  logic [NREQ-1:0][W-1:0]              req_b_i,
   input  logic [NREQ-1:0][$clog2(W)-1:0]      req_shamt_i,
   input  logic [NREQ-1:0][TAGW-1:0]           req_tag_i,
   output logic                                alu_valid_o,
   output uop_pkg::op_t                        alu_op_o,
   output logic [W-1:0]                        alu_a_o,
   output logic [W-1:0]                        alu_b_o,
   output logic [$clog2(W)-1:0]                alu_shamt_o,
   input  logic [W-1:0]                        alu_y_i,
   output logic                                rsp_valid_o,
   input  logic                                rsp_ready_i,
   output logic [W-1:0]                        rsp_y_o,
   output logic [$clog2(NREQ)-1:0]             rsp_id_o,
   output logic [TAGW-1:0]                     rsp_tag_o
`ifdef UOP_SCHED_STATS_EN
   ,
   output logic [31:0]                         stat_issued_o,
   output logic [31:0]                         stat_stall_o
`endif
);

   localparam int IDW = $clog2(NREQ);
   localparam int SW  = $clog2(W);
   localparam int CW  = $clog2(RDEPTH + 1);
   localparam int PW  = $clog2(RDEPTH);

   typedef struct packed {
      logic            vld;
      logic [IDW-1:0]  id;
      logic [TAGW-1:0] tag;
   } tp_t;

   typedef struct packed {
      logic [W-1:0]    y;
      logic [IDW-1:0]  id;
      logic [TAGW-1:0] tag;
   } rsp_t;

   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]  credits_q, credits_d;
   logic [IDW-1:0] grant_idx, cand;
   logic           grant_found, can_issue, req_hs, rsp_hs;

   logic           alu_valid_q;
   uop_pkg::op_t   alu_op_q;
   logic [W-1:0]   alu_a_q, alu_b_q;
   logic [SW-1:0]  alu_shamt_q;

   tp_t            pipe_q [LAT+1];
   rsp_t           fifo_q [RDEPTH];
   logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]  count_q, count_d;
   logic           fifo_wr;

   // Search upward from rr_ptr, wrapping, for the first valid requester.
   always_comb begin
      // NOTE: every variable gets a default before the search so no latch is inferred.
      grant_idx   = '0;
      grant_found = 1'b0;
      cand        = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = IDW'((int'(rr_ptr_q) + i) % NREQ);
         if (!grant_found && req_valid_i[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   assign can_issue   = !rst_i && (credits_q < CW'(RDEPTH));
   assign req_hs      = grant_found && can_issue;
   assign req_ready_o = req_hs ? (NREQ'(1) << grant_idx) : '0;
   assign rsp_hs      = rsp_valid_o && rsp_ready_i;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (req_hs) begin
         rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
      end
   end

   always_comb begin
      credits_d = credits_q;
      case ({req_hs, rsp_hs})
         2'b10:   credits_d = credits_q + CW'(1);
         2'b01:   credits_d = credits_q - CW'(1);
         default: credits_d = credits_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q    <= '0;
         credits_q   <= '0;
         alu_valid_q <= 1'b0;
         alu_op_q    <= uop_pkg::OP_NOP;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_shamt_q <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         credits_q   <= credits_d;
         alu_valid_q <= req_hs;
         if (req_hs) begin
            alu_op_q    <= req_op_i[grant_idx];
            alu_a_q     <= req_a_i[grant_idx];
            alu_b_q     <= req_b_i[grant_idx];
            alu_shamt_q <= req_shamt_i[grant_idx];
         end
      end
   end

   assign alu_valid_o = alu_valid_q;
   assign alu_op_o    = alu_op_q;
   assign alu_a_o     = alu_a_q;
   assign alu_b_o     = alu_b_q;
   assign alu_shamt_o = alu_shamt_q;

   // Stage 0 lines up with alu_valid; stage LAT lines up with the cycle alu_y is valid.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k <= LAT; k++) pipe_q[k] <= '0;
      end else begin
         pipe_q[0] <= '{vld: req_hs, id: grant_idx, tag: req_tag_i[grant_idx]};
         for (int k = 1; k <= LAT; k++) pipe_q[k] <= pipe_q[k-1];
      end
   end

   assign fifo_wr = pipe_q[LAT].vld;

   // NOTE: the FIFO storage has no reset; the pointers and count alone define which entries are live.
   always_ff @(posedge clk_i) begin
      if (fifo_wr) fifo_q[wr_ptr_q] <= '{y: alu_y_i, id: pipe_q[LAT].id, tag: pipe_q[LAT].tag};
   end

   always_comb begin
      count_d = count_q;
      case ({fifo_wr, rsp_hs})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         count_q <= count_d;
         if (fifo_wr) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (rsp_hs)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
   end

   assign rsp_valid_o = (count_q != '0);
   assign rsp_y_o     = fifo_q[rd_ptr_q].y;
   assign rsp_id_o    = fifo_q[rd_ptr_q].id;
   assign rsp_tag_o   = fifo_q[rd_ptr_q].tag;

`ifdef UOP_SCHED_STATS_EN
   logic [31:0] stat_issued_q, stat_stall_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stat_issued_q <= '0;
         stat_stall_q  <= '0;
      end else begin
         if (req_hs) stat_issued_q <= stat_issued_q + 32'd1;
         if ((|req_valid_i) && (credits_q == CW'(RDEPTH))) stat_stall_q <= stat_stall_q + 32'd1;
      end
   end

   assign stat_issued_o = stat_issued_q;
   assign stat_stall_o  = stat_stall_q;
`endif

endmodule

// File: tb/tb_uop_share_sched.sv
// Directed bench for uop_share_sched: external ALU model plus an in-order response scoreboard.
// Define UOP_SCHED_STATS_EN to also check the statistics counters.

module tb_uop_share_sched;
   import uop_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [3:0]        req_valid = '0;
   logic [3:0]        req_ready;
   op_t  [3:0]        req_op = {OP_NOP, OP_NOP, OP_NOP, OP_NOP};
   logic [3:0][63:0]  req_a = '0;
   logic [3:0][63:0]  req_b = '0;
   logic [3:0][5:0]   req_shamt = '0;
   logic [3:0][3:0]   req_tag = '0;
   logic              alu_valid;
   op_t               alu_op;
   logic [63:0]       alu_a, alu_b, alu_y;
   logic [5:0]        alu_shamt;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [63:0]       rsp_y;
   logic [1:0]        rsp_id;
   logic [3:0]        rsp_tag;
`ifdef UOP_SCHED_STATS_EN
   logic [31:0]       stat_issued, stat_stall;
`endif

   always #5 clk = ~clk;

   uop_share_sched #(.NREQ(4), .W(64), .LAT(3), .RDEPTH(4), .TAGW(4)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
      .req_a_i(req_a), .req_b_i(req_b), .req_shamt_i(req_shamt), .req_tag_i(req_tag),
      .alu_valid_o(alu_valid), .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
      .alu_shamt_o(alu_shamt), .alu_y_i(alu_y),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_y_o(rsp_y),
      .rsp_id_o(rsp_id), .rsp_tag_o(rsp_tag)
`ifdef UOP_SCHED_STATS_EN
      , .stat_issued_o(stat_issued), .stat_stall_o(stat_stall)
`endif
   );

   function automatic logic [63:0] alu_f(op_t op, logic [63:0] a, logic [63:0] b, logic [5:0] sh);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_SLL:  return a << sh;
         OP_SRL:  return a >> sh;
         OP_SRA:  return $signed(a) >>> sh;
         default: return 64'd0;
      endcase
   endfunction

   // External 3-cycle ALU: result of the alu_* registers appears on alu_y three cycles later.
   logic [63:0] alu_p0, alu_p1, alu_p2;
   always @(posedge clk) begin
      alu_p0 <= alu_f(alu_op, alu_a, alu_b, alu_shamt);
      alu_p1 <= alu_p0;
      alu_p2 <= alu_p1;
   end
   assign alu_y = alu_p2;

   typedef struct packed {
      logic [63:0] y;
      logic [1:0]  id;
      logic [3:0]  tag;
   } exp_t;

   exp_t sb[$];
   int   hs_log[$];
   int   hs_cyc[$];
   int   cyc;
   logic last_hs;
   int   n_tests = 0;
   int   n_fail  = 0;

   // Book-keeps the current cycle: response scoreboard and request handshake log.
   task automatic settle();
      #1;
      if (rst) begin
         sb.delete();
      end else begin
         if (rsp_valid && rsp_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL rsp_unexpected: got y=%h id=%0d tag=%0d, required no response", rsp_y, rsp_id, rsp_tag);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if ({rsp_y, rsp_id, rsp_tag} !== e) begin
                  n_fail++;
                  $display("FAIL rsp_data: got y=%h id=%0d tag=%0d, required y=%h id=%0d tag=%0d",
                           rsp_y, rsp_id, rsp_tag, e.y, e.id, e.tag);
               end
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               sb.push_back('{y: alu_f(req_op[i], req_a[i], req_b[i], req_shamt[i]), id: 2'(i), tag: req_tag[i]});
               hs_log.push_back(i);
               hs_cyc.push_back(cyc);
            end
         end
      end
      last_hs = |(req_valid & req_ready);
   endtask

   task automatic advance();
      @(negedge clk);
      #1;
      cyc++;
   endtask

   task automatic step();
      settle();
      advance();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      step();
      rst = 1'b0;
      cyc = 0;
      hs_log.delete();
      hs_cyc.delete();
   endtask

   task automatic drain();
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int c = 0; c < 30 && (sb.size() != 0 || rsp_valid); c++) step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      settle();
      n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready_gated: got %b, required 0000", req_ready); end
      advance();
      rst = 1'b0;
      req_valid = '0;
      n_tests++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL rst_alu_valid: got %b, required 0", alu_valid); end
      n_tests++; if (alu_op !== OP_NOP) begin n_fail++; $display("FAIL rst_alu_op: got %0d, required %0d", alu_op, OP_NOP); end
      n_tests++; if ({alu_a, alu_b, alu_shamt} !== '0) begin n_fail++; $display("FAIL rst_alu_operands: got a=%h b=%h sh=%h, required 0", alu_a, alu_b, alu_shamt); end
      n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b, required 0", rsp_valid); end
      settle();
      n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready_idle: got %b, required 0000", req_ready); end
      advance();
   endtask

   task automatic test_single_op();
      do_reset();
      rsp_ready = 1'b1;
      req_valid = 4'b0001;
      req_op[0] = OP_ADD; req_a[0] = 64'd5; req_b[0] = 64'd7; req_shamt[0] = '0; req_tag[0] = 4'd3;
      settle();
      n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b, required 0001", req_ready); end
      advance();
      req_valid = '0;
      n_tests++; if (alu_valid !== 1'b1) begin n_fail++; $display("FAIL single_alu_valid: got %b, required 1", alu_valid); end
      n_tests++; if (alu_op !== OP_ADD || alu_a !== 64'd5 || alu_b !== 64'd7) begin n_fail++; $display("FAIL single_alu_regs: got op=%0d a=%0d b=%0d, required op=%0d a=5 b=7", alu_op, alu_a, alu_b, OP_ADD); end
      step();
      n_tests++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL single_alu_pulse: got %b, required 0", alu_valid); end
      for (int k = 2; k <= 4; k++) begin
         n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_rsp: t+%0d got %b, required 0", k, rsp_valid); end
         step();
      end
      n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid: got %b, required 1", rsp_valid); end
      n_tests++; if (rsp_y !== 64'd12 || rsp_id !== 2'd0 || rsp_tag !== 4'd3) begin n_fail++; $display("FAIL single_rsp: got y=%0d id=%0d tag=%0d, required 12 0 3", rsp_y, rsp_id, rsp_tag); end
      step();
      n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop: got %b, required 0", rsp_valid); end
   endtask

   task automatic setup_ops();
      req_op[0] = OP_ADD; req_a[0] = 64'd100;  req_b[0] = 64'd1;   req_shamt[0] = 6'd0; req_tag[0] = 4'd10;
      req_op[1] = OP_SUB; req_a[1] = 64'd50;   req_b[1] = 64'd8;   req_shamt[1] = 6'd0; req_tag[1] = 4'd11;
      req_op[2] = OP_XOR; req_a[2] = 64'hF0;   req_b[2] = 64'hFF;  req_shamt[2] = 6'd0; req_tag[2] = 4'd12;
      req_op[3] = OP_SRA; req_a[3] = 64'hF000_0000_0000_0000; req_b[3] = '0; req_shamt[3] = 6'd4; req_tag[3] = 4'd13;
   endtask

   task automatic test_fairness();
      int exp_ord[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      int exp_cyc[8] = '{0, 1, 2, 3, 6, 7, 8, 9};
      do_reset();
      rsp_ready = 1'b1;
      setup_ops();
      req_valid = 4'b1111;
      for (int c = 0; c < 40 && hs_log.size() < 8; c++) begin
         n_tests++; if (alu_valid !== last_hs) begin n_fail++; $display("FAIL fair_alu_valid: cycle %0d got %b, required %b", cyc, alu_valid, last_hs); end
         step();
      end
      req_valid = '0;
      n_tests++; if (alu_valid !== 1'b1) begin n_fail++; $display("FAIL fair_last_issue: got %b, required 1", alu_valid); end
      n_tests++;
      if (hs_log.size() != 8) begin
         n_fail++; $display("FAIL fair_count: got %0d handshakes, required 8", hs_log.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (hs_log[i] != exp_ord[i] || hs_cyc[i] != exp_cyc[i]) begin
               n_fail++; $display("FAIL fair_order: grant %0d got req%0d@%0d, required req%0d@%0d", i, hs_log[i], hs_cyc[i], exp_ord[i], exp_cyc[i]);
            end
         end
      end
      drain();
      n_tests++; if (sb.size() != 0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL fair_drain: got %0d pending rsp_valid=%b, required 0 0", sb.size(), rsp_valid); end
   endtask

   task automatic bp_cycle(input logic [3:0] exp_ready, input string nm);
      settle();
      n_tests++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL %s: cycle %0d got %b, required %b", nm, cyc, req_ready, exp_ready); end
      advance();
      if (last_hs) begin
         req_a[0]   = 64'd100 + 64'(hs_log.size());
         req_tag[0] = 4'(hs_log.size());
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      rsp_ready = 1'b0;
      req_op[0] = OP_ADD; req_a[0] = 64'd100; req_b[0] = 64'd2; req_shamt[0] = '0; req_tag[0] = 4'd0;
      req_valid = 4'b0001;
      for (int c = 0; c < 10; c++) bp_cycle((c < 4) ? 4'b0001 : 4'b0000, "bp_ready");
      n_tests++; if (hs_log.size() != 4) begin n_fail++; $display("FAIL bp_handshakes: got %0d, required 4", hs_log.size()); end
      n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_buffered: got %b, required 1", rsp_valid); end
`ifdef UOP_SCHED_STATS_EN
      n_tests++; if (stat_issued !== 32'd4 || stat_stall !== 32'd6) begin n_fail++; $display("FAIL bp_stats: got issued=%0d stall=%0d, required 4 6", stat_issued, stat_stall); end
`endif
      rsp_ready = 1'b1;
      bp_cycle(4'b0000, "bp_pop_cycle");
      bp_cycle(4'b0001, "bp_resume");
   endtask

   task automatic test_simultaneous();
      bp_cycle(4'b0001, "sim_credit_hold");
      bp_cycle(4'b0001, "sim_credit_hold");
      bp_cycle(4'b0001, "sim_empty_fifo");
      n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sim_fifo_empty: got %b, required 0", rsp_valid); end
      bp_cycle(4'b0000, "sim_full_credit");
      n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL sim_wr_pop: got %b, required 1", rsp_valid); end
      bp_cycle(4'b0000, "sim_pop_no_bypass");
      bp_cycle(4'b0001, "sim_reissue");
      drain();
      n_tests++; if (hs_log.size() != 9 || sb.size() != 0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sim_drain: got hs=%0d pending=%0d rsp_valid=%b, required 9 0 0", hs_log.size(), sb.size(), rsp_valid); end
`ifdef UOP_SCHED_STATS_EN
      n_tests++; if (stat_issued !== 32'd9 || stat_stall !== 32'd9) begin n_fail++; $display("FAIL sim_stats: got issued=%0d stall=%0d, required 9 9", stat_issued, stat_stall); end
`endif
   endtask

   task automatic test_reset_midflight();
      int exp_ord[4] = '{1, 3, 1, 3};
      do_reset();
      rsp_ready = 1'b1;
      setup_ops();
      req_valid = 4'b0111;
      for (int c = 0; c < 3; c++) step();
      req_valid = '0;
      step();
      n_tests++; if (hs_log.size() != 3) begin n_fail++; $display("FAIL mid_issue: got %0d handshakes, required 3", hs_log.size()); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_discard: cycle %0d got rsp_valid=%b, required 0", c, rsp_valid); end
         step();
      end
      hs_log.delete();
      rsp_ready = 1'b0;
      req_valid = 4'b1010;
      settle();
      n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_first_grant: got %b, required 0010", req_ready); end
      advance();
      for (int c = 0; c < 7; c++) step();
      n_tests++;
      if (hs_log.size() != 4) begin
         n_fail++; $display("FAIL mid_credits: got %0d handshakes, required 4", hs_log.size());
      end else begin
         for (int i = 0; i < 4; i++)
            if (hs_log[i] != exp_ord[i]) begin n_fail++; $display("FAIL mid_order: grant %0d got req%0d, required req%0d", i, hs_log[i], exp_ord[i]); end
      end
      drain();
      n_tests++; if (sb.size() != 0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_drain: got %0d pending rsp_valid=%b, required 0 0", sb.size(), rsp_valid); end
   endtask

   task automatic test_wrap();
      int exp_ord[4] = '{2, 3, 1, 3};
      do_reset();
      rsp_ready = 1'b1;
      setup_ops();
      req_valid = 4'b0100;
      step();
      req_valid = 4'b1010;
      for (int c = 0; c < 3; c++) step();
      req_valid = '0;
      n_tests++;
      if (hs_log.size() != 4) begin
         n_fail++; $display("FAIL wrap_count: got %0d handshakes, required 4", hs_log.size());
      end else begin
         for (int i = 0; i < 4; i++)
            if (hs_log[i] != exp_ord[i]) begin n_fail++; $display("FAIL wrap_order: grant %0d got req%0d, required req%0d", i, hs_log[i], exp_ord[i]); end
      end
      drain();
      n_tests++; if (sb.size() != 0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_drain: got %0d pending rsp_valid=%b, required 0 0", sb.size(), rsp_valid); end
   endtask

   initial begin
      cyc = 0;
      last_hs = 1'b0;
      @(negedge clk);
      #1;
      test_reset();
      test_single_op();
      test_fairness();
      test_backpressure();
      test_simultaneous();
      test_reset_midflight();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
